tt_rng_collector: RTL and testbench
===================================

Name: tt_rng_collector

Overview:
Consumer end of the ring-oscillator random bit stream. It drives the ring enable (startring), samples the XORed raw bit each clock, discards a warm-up window and runs a repetition-count health test. It also applies von Neumann debiasing and packs the debiased bits into bytes. Bytes go out on a valid/ready interface to the downstream TT I/O logic.

Parameters:
WARMUP_CYCLES, 16, raw-bit cycles discarded after each ring start (1..255)
REP_LIMIT, 32, consecutive identical raw bits that trip the health test (2..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  request for random data; 0 stops the ring
raw_bit  input  1  registered XOR ring output, one sample per clk
startring  output  1  ring enable to the oscillator block
byte_data  output  8  debiased random byte
byte_valid  output  1  byte_data holds an unconsumed byte
byte_ready  input  1  consumer accepts byte this cycle
health_fail  output  1  sticky repetition-test failure
drop_cnt  output  8  saturating count of bytes lost to a full output

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; startring=0, byte_data=0, byte_valid=0, health_fail=0, drop_cnt=0. Internal warm-up counter, repetition counter, pair register and shift register are all cleared. rst overrides every other input.
- States: IDLE, WARMUP, COLLECT, FAIL.
- IDLE: startring=0. When enable=1 -> WARMUP, warm-up count=0.
- WARMUP: startring=1. Each cycle, warm-up count increments and raw_bit is ignored for data. When count reaches WARMUP_CYCLES-1 -> COLLECT next cycle, so exactly WARMUP_CYCLES samples are discarded.
- COLLECT: startring=1. Raw bits are paired in arrival order (first, second):
  - 01 -> emit 0
  - 10 -> emit 1
  - 00 or 11 -> discard
- Each emitted bit shifts into the LSB of an 8-bit shift register (shift left), so the first emitted bit ends up at byte_data[7]. The 8th emitted bit completes a byte in that same cycle.
- Byte completion when byte_valid=0, or when byte_valid=1 and byte_ready=1 in the same cycle: the byte loads into byte_data and byte_valid=1 next cycle. Back-to-back completion and handshake keeps byte_valid high.
- Byte completion when byte_valid=1 and byte_ready=0: the new byte is dropped, drop_cnt increments (saturates at 255), and byte_data is unchanged.
- The shift register restarts empty after every completion, including a drop.
- Handshake: a transfer occurs when byte_valid and byte_ready are both 1 at a posedge. byte_valid clears next cycle unless a new byte loads. byte_data is stable while byte_valid=1 and no transfer occurs.
- enable=0 in WARMUP or COLLECT: -> IDLE next cycle and startring=0. The pair register, shift register and counters clear. A pending output byte stays valid and deliverable.
- Repetition test: active in WARMUP and COLLECT.
  - The counter is set to 1 on the first sample after entering WARMUP and on every change of raw_bit; it increments on an equal sample.
  - When it reaches REP_LIMIT -> FAIL next cycle.
  - Repetition failure takes priority over warm-up completion and over byte completion in the same cycle.
- FAIL: startring=0, health_fail=1, byte_valid=0 (pending byte discarded), byte_data=0. FAIL ignores enable and byte_ready, and is left only by rst.
- drop_cnt clears only on rst.

Optional Feature:
RNG_BYPASS_VN_EN. When defined, von Neumann debiasing is removed: in COLLECT every raw_bit is shifted in directly, so a byte completes every 8 cycles. The warm-up window and the repetition test are unchanged. When undefined, debiasing behaves as described above.

Test Plan:
- rst, then enable=1 with raw_bit alternating 0,1: startring=1 one cycle after enable; no byte during the first 16 samples; the first byte after warm-up equals 0x00 (every pair is 01). With RNG_BYPASS_VN_EN defined, the first byte is 0x55.
- COLLECT with pairs 10,01,10,01,10,01,10,01 -> byte_data=0xAA, byte_valid=1. Holding byte_ready=1 gives a transfer on the next posedge, then byte_valid=0.
- Hold byte_ready=0 while two further bytes complete -> byte_data still shows the first byte, drop_cnt=2. Then assert byte_ready -> one transfer and byte_valid=0.
- raw_bit held at 1 for 32 cycles in COLLECT -> FAIL: health_fail=1, startring=0, byte_valid=0. Toggling enable has no effect; rst clears health_fail.
- Drop enable mid-byte after 5 emitted bits with a byte pending -> IDLE, startring=0, pending byte still accepted. Re-enable repeats warm-up and the next byte is built from 8 fresh bits.
- raw_bit held at 0 for 31 cycles then toggled -> no failure. Assert rst mid-COLLECT -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/tt_rng_collector.sv
// Ring-oscillator bit collector: warm-up discard, repetition health test, von Neumann debias, byte packing onto valid/ready.
// Optional RNG_BYPASS_VN_EN shifts raw bits in directly. Bytes completing while the output is stalled are dropped and counted.
module tt_rng_collector #(
  parameter int WARMUP_CYCLES = 16,
  parameter int REP_LIMIT     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       raw_bit,
  output logic       startring,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       health_fail,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);
  localparam logic [7:0] REP_MAX   = 8'(REP_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_FAIL} state_t;

  state_t     state_q, state_d;
  logic [7:0] warm_q, warm_d;
  logic [7:0] rep_q, rep_d;
  logic       last_q, last_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [7:0] drop_q, drop_d;
`ifndef RNG_BYPASS_VN_EN
  logic       pair_vld_q, pair_vld_d;
  logic       pair_bit_q, pair_bit_d;
`endif

  logic xfer;
  logic first;
  logic emit;
  logic emit_bit;

  assign xfer = valid_q & byte_ready;

  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    rep_d      = rep_q;
    last_d     = last_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
`ifndef RNG_BYPASS_VN_EN
    pair_vld_d = pair_vld_q;
    pair_bit_d = pair_bit_q;
`endif
    first      = 1'b0;
    emit       = 1'b0;
    emit_bit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) valid_d = 1'b0;
        if (enable) begin
          state_d = S_WARMUP;
          warm_d  = 8'd0;
        end
      end
      S_WARMUP, S_COLLECT: begin
        if (xfer) valid_d = 1'b0;
        if (!enable) begin
          state_d    = S_IDLE;
          warm_d     = 8'd0;
          rep_d      = 8'd0;
          last_d     = 1'b0;
          sr_d       = 8'd0;
          bit_cnt_d  = 3'd0;
`ifndef RNG_BYPASS_VN_EN
          pair_vld_d = 1'b0;
          pair_bit_d = 1'b0;
`endif
        end else begin
          first  = (state_q == S_WARMUP) && (warm_q == 8'd0);
          rep_d  = (first || (raw_bit != last_q)) ? 8'd1 : rep_q + 8'd1;
          last_d = raw_bit;
          // A tripped health test suppresses warm-up exit and any byte completion.
          if (rep_d == REP_MAX) begin
            state_d = S_FAIL;
            valid_d = 1'b0;
            data_d  = 8'd0;
          end else if (state_q == S_WARMUP) begin
            if (warm_q == WARM_LAST) state_d = S_COLLECT;
            else                     warm_d  = warm_q + 8'd1;
          end else begin
`ifdef RNG_BYPASS_VN_EN
            emit     = 1'b1;
            emit_bit = raw_bit;
`else
            if (!pair_vld_q) begin
              pair_vld_d = 1'b1;
              pair_bit_d = raw_bit;
            end else begin
              pair_vld_d = 1'b0;
              emit       = (pair_bit_q != raw_bit);
              emit_bit   = pair_bit_q;
            end
`endif
            if (emit) begin
              if (bit_cnt_q == 3'd7) begin
                sr_d      = 8'd0;
                bit_cnt_d = 3'd0;
                if (!valid_q || byte_ready) begin
                  data_d  = {sr_q[6:0], emit_bit};
                  valid_d = 1'b1;
                end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
                end
              end else begin
                sr_d      = {sr_q[6:0], emit_bit};
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        data_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      warm_q     <= 8'd0;
      rep_q      <= 8'd0;
      last_q     <= 1'b0;
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      drop_q     <= 8'd0;
`ifndef RNG_BYPASS_VN_EN
      pair_vld_q <= 1'b0;
      pair_bit_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      rep_q      <= rep_d;
      last_q     <= last_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
`ifndef RNG_BYPASS_VN_EN
      pair_vld_q <= pair_vld_d;
      pair_bit_q <= pair_bit_d;
`endif
    end
  end

  assign startring   = (state_q == S_WARMUP) || (state_q == S_COLLECT);
  assign health_fail = (state_q == S_FAIL);
  assign byte_data   = data_q;
  assign byte_valid  = valid_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_tt_rng_collector.sv
// Bench for tt_rng_collector: queue-based behavioural model compared every cycle, directed scenarios pinned with literals, then random traffic.
module tb_tt_rng_collector;
  localparam int W   = 16;
  localparam int REP = 32;

  logic       clk = 1'b0;
  logic       rst, enable, raw_bit, byte_ready;
  logic       startring, byte_valid, health_fail;
  logic [7:0] byte_data, drop_cnt;

  always #5 clk = ~clk;

  tt_rng_collector #(.WARMUP_CYCLES(W), .REP_LIMIT(REP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .raw_bit(raw_bit),
    .startring(startring), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .health_fail(health_fail), .drop_cnt(drop_cnt)
  );

  int errs = 0;
  int checks = 0;

  // Model: 0 idle, 1 warm-up, 2 collect, 3 fail
  int         m_mode = 0;
  int         m_seen = 0;
  int         m_run = 0;
  bit         m_last = 0;
  bit         pairq[$];
  bit         bitsq[$];
  bit         m_vld = 0;
  logic [7:0] m_dat = 8'd0;
  int         m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit xfer;
    logic [7:0] b;
    if (rst) begin
      m_mode = 0; m_seen = 0; m_run = 0; m_last = 0;
      pairq.delete(); bitsq.delete();
      m_vld = 0; m_dat = 8'd0; m_drop = 0;
      return;
    end
    xfer = m_vld && byte_ready;
    if (m_mode == 0) begin
      if (xfer) m_vld = 0;
      if (enable) begin m_mode = 1; m_seen = 0; end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (!enable) begin
        m_mode = 0; m_seen = 0; m_run = 0;
        pairq.delete(); bitsq.delete();
        if (xfer) m_vld = 0;
      end else begin
        m_run  = (m_seen == 0 || raw_bit != m_last) ? 1 : m_run + 1;
        m_last = raw_bit;
        m_seen++;
        if (m_run >= REP) begin
          m_mode = 3; m_vld = 0; m_dat = 8'd0;
        end else if (m_mode == 1) begin
          if (m_seen == W) m_mode = 2;
          if (xfer) m_vld = 0;
        end else begin
`ifdef RNG_BYPASS_VN_EN
          bitsq.push_back(raw_bit);
`else
          pairq.push_back(raw_bit);
          if (pairq.size() == 2) begin
            if (pairq[0] != pairq[1]) bitsq.push_back(pairq[0]);
            pairq.delete();
          end
`endif
          if (bitsq.size() == 8) begin
            b = 8'd0;
            for (int i = 0; i < 8; i++) b = {b[6:0], bitsq[i]};
            bitsq.delete();
            if (!m_vld || xfer) begin m_vld = 1; m_dat = b; end
            else if (m_drop < 255) m_drop++;
          end else if (xfer) begin
            m_vld = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit d, input bit y);
    rst = r; enable = e; raw_bit = d; byte_ready = y;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("startring",   startring,   (m_mode == 1 || m_mode == 2));
    chk("byte_valid",  byte_valid,  m_vld);
    chk("byte_data",   byte_data,   m_dat);
    chk("health_fail", health_fail, (m_mode == 3));
    chk("drop_cnt",    drop_cnt,    m_drop);
  endtask

  // 10,01 pairs repeated: 1,0,0,1
  function automatic bit aa(input int i);
    return ((i % 4) == 0) || ((i % 4) == 3);
  endfunction

  int p_raw, p_rdy;

  initial begin
    rst = 1'b1; enable = 1'b0; raw_bit = 1'b0; byte_ready = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_startring", startring, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 8'h00);
    chk("rst_health", health_fail, 0);
    chk("rst_drop", drop_cnt, 0);

    cyc(0, 1, 0, 0);
    chk("startring_after_en", startring, 1);
    for (int i = 0; i < W; i++) begin
      cyc(0, 1, i % 2, 0);
      chk("no_byte_in_warmup", byte_valid, 0);
    end
`ifdef RNG_BYPASS_VN_EN
    for (int i = 0; i < 8; i++) cyc(0, 1, i % 2, 0);
    chk("first_byte_valid", byte_valid, 1);
    chk("first_byte_data", byte_data, 8'h55);
`else
    for (int i = 0; i < 16; i++) cyc(0, 1, i % 2, 0);
    chk("first_byte_valid", byte_valid, 1);
    chk("first_byte_data", byte_data, 8'h00);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, aa(i), i == 0);
      if (i == 0) chk("valid_clear_after_xfer", byte_valid, 0);
    end
    chk("aa_valid", byte_valid, 1);
    chk("aa_data", byte_data, 8'hAA);

    for (int i = 0; i < 32; i++) cyc(0, 1, aa(i), 0);
    chk("stall_data_held", byte_data, 8'hAA);
    chk("stall_drop2", drop_cnt, 2);
    cyc(0, 1, 0, 1);
    chk("stall_release", byte_valid, 0);
    cyc(0, 1, 0, 0);

    for (int i = 0; i < 16; i++) cyc(0, 1, aa(i), 0);
    chk("pending_valid", byte_valid, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, aa(i), 0);
    cyc(0, 0, 0, 0);
    chk("disable_ring_off", startring, 0);
    chk("disable_keeps_byte", byte_valid, 1);
    cyc(0, 0, 0, 1);
    chk("idle_delivery", byte_valid, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < W; i++) cyc(0, 1, i % 2, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, aa(i), 0);
    chk("fresh_byte_valid", byte_valid, 1);
    chk("fresh_byte_data", byte_data, 8'hAA);
`endif

    for (int i = 0; i < 31; i++) cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    chk("run31_no_fail", health_fail, 0);
    cyc(1, 1, 1, 1);
    chk("midrst_startring", startring, 0);
    chk("midrst_valid", byte_valid, 0);
    chk("midrst_data", byte_data, 8'h00);
    chk("midrst_drop", drop_cnt, 0);

    cyc(0, 1, 0, 0);
    for (int i = 0; i < W; i++) cyc(0, 1, i % 2, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 31; i++) cyc(0, 1, 1, 0);
    chk("run31_ones_ok", health_fail, 0);
    cyc(0, 1, 1, 0);
    chk("run32_fail", health_fail, 1);
    chk("fail_ring_off", startring, 0);
    chk("fail_valid", byte_valid, 0);
    for (int i = 0; i < 6; i++) cyc(0, i % 2, i % 2, 1);
    chk("fail_sticky", health_fail, 1);
    cyc(1, 0, 0, 0);
    chk("fail_rst_clears", health_fail, 0);

    for (int n = 0; n < 20000; n++) begin
      if (n % 256 == 0) begin
        case ($urandom_range(0, 3))
          0: p_raw = 50;
          1: p_raw = 80;
          2: p_raw = 97;
          default: p_raw = 100;
        endcase
        p_rdy = $urandom_range(0, 100);
      end
      cyc(($urandom % 400) == 0, ($urandom % 64) != 0,
          $urandom_range(0, 99) < p_raw, $urandom_range(0, 99) < p_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
